phys_ram_ctrl: RTL and testbench
================================

# phys_ram_ctrl

Parametrised, byte-addressed physical RAM model with a valid/ready request channel, a valid/ready response channel, per-byte write strobes, programmable access latency and out-of-range error reporting. It sits behind the MMU as the backing store for translated physical addresses. It replaces the fixed 32-bit, zero-latency RAM model so the MMU can be exercised against realistic wait states and partial-word stores.

## Interface
Parameters:
- DATA_BYTES, 4: bytes per access; data ports are 8*DATA_BYTES wide. Must be ≥1.
- ADDR_WIDTH, 32: byte-address width.
- MEM_BYTES, 65536: implemented storage in bytes. Must be a power of two and ≤ 2^ADDR_WIDTH.
- LATENCY, 2: edges from request acceptance to response valid. Must be ≥1.
- Any violation is an elaboration error.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- ReqValid  in  1  request present.
- ReqReady  out  1  block can accept a request.
- ReqWrite  in  1  1 = write, 0 = read.
- ReqAddress  in  ADDR_WIDTH  byte address of lane 0.
- ReqByteEnable  in  DATA_BYTES  per-lane enable.
- WriteValue  in  8*DATA_BYTES  write data; lane i = bits [8i+7:8i].
- RespValid  out  1  response present.
- RespReady  in  1  consumer accepts the response.
- ReadValue  out  8*DATA_BYTES  read data.
- RespError  out  1  request address out of range.

## Operation
- States: IDLE, BUSY, RESP. Reset (sampled at an edge) forces IDLE, counter 0, RespValid=0, RespError=0, ReadValue=0. ReqReady=0 while reset is high.
- ReqReady = 1 iff state==IDLE and reset==0. Acceptance = ReqValid&&ReqReady at an edge. On acceptance, latch ReqWrite, ReqAddress, ReqByteEnable, WriteValue; counter ← LATENCY-1; go to BUSY.
- BUSY: while counter≠0, decrement. At the edge where counter==0, perform the access and go to RESP.
- Access, lane i: byte address = (A + i) mod MEM_BYTES, little-endian (lane 0 at A). No alignment requirement; a word crossing the top of storage wraps to byte 0.
- Write: store each enabled lane only. Set ReadValue=0.
- Read: ReadValue lane i = mem byte if enabled, else 0x00.
- Error: if latched A ≥ MEM_BYTES, set RespError=1, do not modify memory, and set ReadValue=0. Otherwise RespError=0.
- An all-zero byte enable is legal. It produces a full response with no memory change and ReadValue=0.
- RESP: RespValid=1. ReadValue and RespError are held stable until RespValid&&RespReady at an edge, which returns the block to IDLE with RespValid=0.
- Inputs presented outside IDLE are ignored; the requester must hold them until ReqReady.
- Memory contents are not cleared by reset and are undefined until written.
- Reset mid-operation: a transaction in BUSY is abandoned. A pending write is performed only if its access edge precedes the reset edge. A response in RESP is dropped.

## Timing
- Acceptance at edge T. The access and RespValid rise occur at edge T+LATENCY.
- With RespReady held high, the handshake occurs at edge T+LATENCY+1, and ReqReady is high again after that edge.
- Earliest next acceptance is edge T+LATENCY+2. Throughput is 1 request per LATENCY+2 cycles, with no overlap.
- Response back-pressure stalls indefinitely with outputs stable.
- A read issued after a write's handshake observes the written data.

## Test plan
- Defaults. Write A=0x0, WriteValue=0xDEADBEEF, enable 0xF. Then read A=0x0, enable 0xF. Expect ReadValue=0xDEADBEEF, bytes 0..3 = EF,BE,AD,DE, and RespValid rising exactly 2 edges after acceptance.
- Partial store. Write 0x11223344 to 0x7000 with enable 0xF. Then write 0xAABBCCDD to 0x7000 with enable 0x5. Read 0x7000 with enable 0xF → 0x11BB33DD. Read with enable 0x6 → 0x00BB3300.
- Unaligned and wrap. Write 0x01020304 to 0xFFFE. Read 0x0000 with enable 0x3 → 0x00000102. Read 0xFFFE → 0x01020304.
- Error. Write to 0x00010000 → RespError=1, ReadValue=0, memory unchanged. A following in-range read → RespError=0.
- Back-pressure. Hold RespReady=0 for 5 cycles: RespValid, ReadValue and RespError stay stable and ReqReady stays 0. A ReqValid pulse during the stall is not accepted.
- Reset. Assert reset one cycle after accepting a write with LATENCY=4. Afterwards RespValid=0, ReqReady=1, and a read of that address returns the prior contents.

Source files
------------

// File: rtl/phys_ram_ctrl.sv
// rtl/phys_ram_ctrl.sv - byte-addressed physical RAM model with programmable latency,
// per-byte strobes and out-of-range error reporting, behind valid/ready channels.
module phys_ram_ctrl #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 65536,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ReqValid,
  output logic                    ReqReady,
  input  logic                    ReqWrite,
  input  logic [ADDR_WIDTH-1:0]   ReqAddress,
  input  logic [DATA_BYTES-1:0]   ReqByteEnable,
  input  logic [8*DATA_BYTES-1:0] WriteValue,
  output logic                    RespValid,
  input  logic                    RespReady,
  output logic [8*DATA_BYTES-1:0] ReadValue,
  output logic                    RespError
);

  localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (DATA_BYTES < 1) begin : g_bad_data_bytes
    $error("phys_ram_ctrl: DATA_BYTES must be >= 1");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("phys_ram_ctrl: LATENCY must be >= 1");
  end
  if ((MEM_BYTES < 1) || ((MEM_BYTES & (MEM_BYTES - 1)) != 0)) begin : g_bad_mem_pow2
    $error("phys_ram_ctrl: MEM_BYTES must be a power of two");
  end
  if (longint'(MEM_BYTES) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_mem_size
    $error("phys_ram_ctrl: MEM_BYTES exceeds the address space");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_BYTES-1:0]   be_q;
  logic [8*DATA_BYTES-1:0] wdata_q;
  logic                    accept, do_access, resp_done, in_range;

  logic [7:0] mem [MEM_BYTES];

  // Lane i lives at (A + i) mod MEM_BYTES, so a word crossing the top wraps to byte 0.
  function automatic logic [IDX_W-1:0] lane_idx(input logic [ADDR_WIDTH-1:0] a, input int i);
    logic [ADDR_WIDTH-1:0] s;
    s = a + ADDR_WIDTH'(i);
    return s[IDX_W-1:0] & IDX_W'(MEM_BYTES - 1);
  endfunction

  assign in_range  = ({1'b0, addr_q} < (ADDR_WIDTH + 1)'(MEM_BYTES));
  assign ReqReady  = (state_q == IDLE) && !reset;
  assign RespValid = (state_q == RESP);

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    do_access = 1'b0;
    resp_done = 1'b0;
    case (state_q)
      IDLE: if (ReqValid) begin
        accept  = 1'b1;
        state_d = BUSY;
      end
      BUSY: if (cnt_q == '0) begin
        do_access = 1'b1;
        state_d   = RESP;
      end
      RESP: if (RespReady) begin
        resp_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ReadValue <= '0;
      RespError <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= CNT_W'(LATENCY - 1);
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (do_access) begin
        RespError <= !in_range;
        for (int i = 0; i < DATA_BYTES; i++) begin
          ReadValue[8*i +: 8] <= (in_range && !wr_q && be_q[i]) ? mem[lane_idx(addr_q, i)] : 8'h00;
        end
      end
    end
  end

  // Request fields are only consulted after acceptance, so they need no reset.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      wr_q    <= ReqWrite;
      addr_q  <= ReqAddress;
      be_q    <= ReqByteEnable;
      wdata_q <= WriteValue;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_access && wr_q && in_range) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (be_q[i]) mem[lane_idx(addr_q, i)] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_phys_ram_ctrl.sv
// tb/tb_phys_ram_ctrl.sv - directed bench for phys_ram_ctrl at LATENCY 2 and LATENCY 4.
module tb_phys_ram_ctrl;

  logic        clk;
  logic [1:0]  reset, req_valid, req_ready, req_write, resp_valid, resp_ready, resp_error;
  logic [31:0] req_addr [2];
  logic [3:0]  req_be   [2];
  logic [31:0] wval     [2];
  logic [31:0] rval     [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  phys_ram_ctrl #(.DATA_BYTES(4), .ADDR_WIDTH(32), .MEM_BYTES(65536), .LATENCY(2)) dut (
    .clk(clk), .reset(reset[0]),
    .ReqValid(req_valid[0]), .ReqReady(req_ready[0]), .ReqWrite(req_write[0]),
    .ReqAddress(req_addr[0]), .ReqByteEnable(req_be[0]), .WriteValue(wval[0]),
    .RespValid(resp_valid[0]), .RespReady(resp_ready[0]), .ReadValue(rval[0]),
    .RespError(resp_error[0])
  );

  phys_ram_ctrl #(.DATA_BYTES(4), .ADDR_WIDTH(32), .MEM_BYTES(65536), .LATENCY(4)) dut4 (
    .clk(clk), .reset(reset[1]),
    .ReqValid(req_valid[1]), .ReqReady(req_ready[1]), .ReqWrite(req_write[1]),
    .ReqAddress(req_addr[1]), .ReqByteEnable(req_be[1]), .WriteValue(wval[1]),
    .RespValid(resp_valid[1]), .RespReady(resp_ready[1]), .ReadValue(rval[1]),
    .RespError(resp_error[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction with RespReady high; lat = edges from acceptance to RespValid.
  task automatic xact(input int d, input logic wr, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, output logic [31:0] r, output logic e, output int l);
    int n;
    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = a; req_be[d] = be;
    wval[d] = wd; resp_ready[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    l = 0;
    while (!resp_valid[d] && l < 50) begin @(posedge clk); #1; l++; end
    r = rval[d];
    e = resp_error[d];
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 2'b11; req_valid = '0; req_write = '0; resp_ready = '0;
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = '0; req_be[d] = '0; wval[d] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_reqready", 32'(req_ready[0]), 32'd0);
    chk("reset_respvalid", 32'(resp_valid[0]), 32'd0);
    chk("reset_readvalue", rval[0], 32'h0);
    chk("reset_resperror", 32'(resp_error[0]), 32'd0);
    reset = 2'b00;
    #1;
    chk("idle_reqready", 32'(req_ready[0]), 32'd1);

    xact(0, 1'b1, 32'h0, 4'hF, 32'hDEADBEEF, rd, er, lat);
    chk("wr0_latency", 32'(lat), 32'd2);
    chk("wr0_readvalue", rd, 32'h0);
    chk("wr0_error", 32'(er), 32'd0);
    chk("after_hs_reqready", 32'(req_ready[0]), 32'd1);
    xact(0, 1'b0, 32'h0, 4'hF, 32'h0, rd, er, lat);
    chk("rd0_latency", 32'(lat), 32'd2);
    chk("rd0_value", rd, 32'hDEADBEEF);
    xact(0, 1'b0, 32'h1, 4'h1, 32'h0, rd, er, lat);
    chk("rd1_byte_be", rd, 32'h000000BE);

    xact(0, 1'b1, 32'h7000, 4'hF, 32'h11223344, rd, er, lat);
    xact(0, 1'b1, 32'h7000, 4'h5, 32'hAABBCCDD, rd, er, lat);
    xact(0, 1'b0, 32'h7000, 4'hF, 32'h0, rd, er, lat);
    chk("partial_full_read", rd, 32'h11BB33DD);
    xact(0, 1'b0, 32'h7000, 4'h6, 32'h0, rd, er, lat);
    chk("partial_be6_read", rd, 32'h00BB3300);
    xact(0, 1'b0, 32'h7000, 4'h0, 32'h0, rd, er, lat);
    chk("zero_be_read", rd, 32'h0);
    chk("zero_be_error", 32'(er), 32'd0);

    xact(0, 1'b1, 32'hFFFE, 4'hF, 32'h01020304, rd, er, lat);
    xact(0, 1'b0, 32'h0000, 4'h3, 32'h0, rd, er, lat);
    chk("wrap_low_read", rd, 32'h00000102);
    xact(0, 1'b0, 32'hFFFE, 4'hF, 32'h0, rd, er, lat);
    chk("wrap_full_read", rd, 32'h01020304);

    xact(0, 1'b1, 32'h00010000, 4'hF, 32'h55667788, rd, er, lat);
    chk("oor_write_error", 32'(er), 32'd1);
    chk("oor_write_value", rd, 32'h0);
    xact(0, 1'b0, 32'h00010000, 4'hF, 32'h0, rd, er, lat);
    chk("oor_read_error", 32'(er), 32'd1);
    chk("oor_read_value", rd, 32'h0);
    xact(0, 1'b0, 32'h0, 4'hF, 32'h0, rd, er, lat);
    chk("post_oor_error", 32'(er), 32'd0);
    chk("post_oor_mem", rd, 32'hDEAD0102);

    // Response back-pressure with a spurious write pulse during the stall.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h7000; req_be[0] = 4'hF;
    resp_ready[0] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    lat = 0;
    while (!resp_valid[0] && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("bp_latency", 32'(lat), 32'd2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid[0] = (c == 2); req_write[0] = 1'b1; wval[0] = 32'h0;
      chk("bp_respvalid", 32'(resp_valid[0]), 32'd1);
      chk("bp_readvalue", rval[0], 32'h11BB33DD);
      chk("bp_resperror", 32'(resp_error[0]), 32'd0);
      chk("bp_reqready", 32'(req_ready[0]), 32'd0);
    end
    @(negedge clk);
    req_valid[0] = 1'b0; resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_respvalid", 32'(resp_valid[0]), 32'd0);
    chk("bp_release_reqready", 32'(req_ready[0]), 32'd1);
    xact(0, 1'b0, 32'h7000, 4'hF, 32'h0, rd, er, lat);
    chk("bp_pulse_ignored", rd, 32'h11BB33DD);

    // Reset one cycle after accepting a write on the LATENCY=4 instance.
    xact(1, 1'b1, 32'h100, 4'hF, 32'hCAFEF00D, rd, er, lat);
    chk("l4_latency", 32'(lat), 32'd4);
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h100; req_be[1] = 4'hF;
    wval[1] = 32'h12345678;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    reset[1] = 1'b1;
    @(negedge clk);
    chk("l4_reset_reqready", 32'(req_ready[1]), 32'd0);
    chk("l4_reset_respvalid", 32'(resp_valid[1]), 32'd0);
    reset[1] = 1'b0;
    #1;
    chk("l4_post_reqready", 32'(req_ready[1]), 32'd1);
    repeat (6) @(negedge clk);
    chk("l4_post_respvalid", 32'(resp_valid[1]), 32'd0);
    xact(1, 1'b0, 32'h100, 4'hF, 32'h0, rd, er, lat);
    chk("l4_abandoned_write", rd, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
